// File: rtl/mips_ctrl_pkg.sv
// Shared MIPS control encodings: ALU ops, PC source, compare results, MDU and
// HI/LO codes, opcode/funct values and the ID/EX control payload.
package mips_ctrl_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned REG_W   = 5;
    localparam int unsigned CNT_W   = 4;

    typedef enum logic [3:0] {
        A_NOP  = 4'd0,  A_ADD  = 4'd1,  A_ADDU = 4'd2,  A_SUB  = 4'd3,
        A_SUBU = 4'd4,  A_AND  = 4'd5,  A_OR   = 4'd6,  A_XOR  = 4'd7,
        A_NOR  = 4'd8,  A_SLT  = 4'd9,  A_SLTU = 4'd10, A_SLL  = 4'd11,
        A_SRL  = 4'd12, A_SRA  = 4'd13, A_PASS = 4'd14, A_LUI  = 4'd15
    } alu_op_e;

    typedef enum logic [1:0] {PC_PLUS4, PC_BRANCH, PC_JUMP, PC_JR} pc_src_e;
    typedef enum logic [1:0] {CMP_LT, CMP_EQ, CMP_GT} cmp_e;
    typedef enum logic [1:0] {MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU} mdu_op_e;
    typedef enum logic [1:0] {HILO_NONE, HILO_HI, HILO_LO} hilo_e;
    typedef enum logic [1:0] {DST_RT, DST_RD, DST_RA} reg_dst_e;
    typedef enum logic [1:0] {BSEL_RT, BSEL_SIMM, BSEL_ZIMM} b_sel_e;
    typedef enum logic {MDU_IDLE, MDU_BUSY} mdu_state_e;

    localparam logic [5:0] OP_SPECIAL = 6'h00, OP_REGIMM = 6'h01, OP_J     = 6'h02,
                           OP_BEQ     = 6'h04, OP_BNE    = 6'h05, OP_BLEZ  = 6'h06,
                           OP_BGTZ    = 6'h07, OP_ADDI   = 6'h08, OP_ADDIU = 6'h09,
                           OP_SLTI    = 6'h0A, OP_SLTIU  = 6'h0B, OP_ANDI  = 6'h0C,
                           OP_ORI     = 6'h0D, OP_XORI   = 6'h0E, OP_LUI   = 6'h0F,
                           OP_LW      = 6'h23, OP_SW     = 6'h2B;

    localparam logic [5:0] F_SLL  = 6'h00, F_SRL  = 6'h02, F_SRA   = 6'h03, F_SLLV = 6'h04,
                           F_SRLV = 6'h06, F_SRAV = 6'h07, F_JR    = 6'h08, F_MOVZ = 6'h0A,
                           F_MOVN = 6'h0B, F_MFHI = 6'h10, F_MFLO  = 6'h12, F_MULT = 6'h18,
                           F_MULTU = 6'h19, F_DIV = 6'h1A, F_DIVU  = 6'h1B, F_ADD  = 6'h20,
                           F_ADDU = 6'h21, F_SUB  = 6'h22, F_SUBU  = 6'h23, F_AND  = 6'h24,
                           F_OR   = 6'h25, F_XOR  = 6'h26, F_NOR   = 6'h27, F_SLT  = 6'h2A,
                           F_SLTU = 6'h2B;

    // ID/EX control payload (everything except ex_valid)
    typedef struct packed {
        reg_dst_e reg_dst;
        logic     alu_a_sel;   // 1 = shamt instead of rs
        b_sel_e   alu_b_sel;
        alu_op_e  alu;
        logic     dmem_read;
        logic     dmem_write;
        logic     dmem_to_reg;
        logic     reg_write;
        hilo_e    hilo_rd;
    } id_ctrl_t;

    // Shift funct low bits: 00 left logical, 10 right logical, 11 right arithmetic
    function automatic alu_op_e shift_alu(input logic [1:0] f);
        case (f)
            2'b00:   return A_SLL;
            2'b10:   return A_SRL;
            default: return A_SRA;
        endcase
    endfunction

endpackage

// File: rtl/mdu_sched.sv
// MDU occupancy tracker: launches a multiply/divide and holds mdu_busy for
// exactly MDU_LAT cycles.
// Ports: clk, rst (sync, active-high), i_launch/i_op (accepted MDU op),
//        o_start (one-cycle launch pulse), o_op, o_busy.
module mdu_sched
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned MDU_LAT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_launch,
    input  mdu_op_e    i_op,
    output logic       o_start,
    output logic [1:0] o_op,
    output logic       o_busy
);

    mdu_state_e       r_state;
    logic [CNT_W-1:0] r_cnt;

    // Occupancy FSM; counter holds remaining busy cycles minus one
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= MDU_IDLE;
            r_cnt   <= '0;
            o_start <= 1'b0;
            o_op    <= '0;
            o_busy  <= 1'b0;
        end else begin
            o_start <= i_launch;
            o_op    <= i_launch ? i_op : 2'd0;
            if (i_launch) begin
                r_state <= MDU_BUSY;
                r_cnt   <= CNT_W'(MDU_LAT - 1);
                o_busy  <= 1'b1;
            end else begin
                case (r_state)
                    MDU_BUSY: begin
                        if (r_cnt == '0) begin
                            r_state <= MDU_IDLE;
                            o_busy  <= 1'b0;
                        end else begin
                            r_cnt  <= r_cnt - CNT_W'(1);
                            o_busy <= 1'b1;
                        end
                    end
                    default: begin
                        r_state <= MDU_IDLE;
                        o_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/id_ctrl_pipe.sv
// ID-stage decode, hazard detection and ID/EX control register.
// Ports: clk/rst (sync, active-high); ID inputs id_valid, instr, compare
//        results, flush; EX load info ex_dmem_read/ex_rt.
//        Combinational: id_ready, pc_src, is_branch.
//        Registered: ID/EX bundle, illegal, MDU start/op/busy.
module id_ctrl_pipe
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned MDU_LAT  = 4,
    parameter int unsigned ALUCTL_W = 5,
    parameter int unsigned EN_MOV   = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                id_valid,
    input  logic [INSTR_W-1:0]  instr,
    input  logic [1:0]          rs_cmp_rt,
    input  logic [1:0]          rs_cmp_zero,
    input  logic                flush,
    input  logic                ex_dmem_read,
    input  logic [REG_W-1:0]    ex_rt,
    output logic                id_ready,
    output logic [1:0]          pc_src,
    output logic                is_branch,
    output logic                ex_valid,
    output logic [1:0]          reg_dst,
    output logic                alu_a_sel,
    output logic [1:0]          alu_b_sel,
    output logic [ALUCTL_W-1:0] alu_ctl,
    output logic                dmem_read,
    output logic                dmem_write,
    output logic                dmem_to_reg,
    output logic                reg_write,
    output logic                mdu_start,
    output logic [1:0]          mdu_op,
    output logic [1:0]          hilo_rd,
    output logic                mdu_busy,
    output logic                illegal
);

    logic [5:0]       w_op, w_funct;
    logic [REG_W-1:0] w_rs, w_rt;
    logic             w_unused_instr;
    id_ctrl_t         w_dec, w_bun;
    logic             w_legal, w_rt_src, w_mdu_cls, w_mdu_launch, w_cti, w_taken;
    mdu_op_e          w_mdu_op;
    pc_src_e          w_tgt;
    logic             w_kill, w_load_use, w_stall, w_accept;

    assign w_op           = instr[31:26];
    assign w_rs           = instr[25:21];
    assign w_rt           = instr[20:16];
    assign w_funct        = instr[5:0];
    assign w_unused_instr = ^instr[15:6];

    // Instruction decode
    always_comb begin
        w_dec        = '0;
        w_legal      = 1'b0;
        w_rt_src     = 1'b0;
        w_mdu_cls    = 1'b0;
        w_mdu_launch = 1'b0;
        w_mdu_op     = MDU_MULT;
        w_cti        = 1'b0;
        w_taken      = 1'b0;
        w_tgt        = PC_PLUS4;
        case (w_op)
            OP_SPECIAL: begin
                case (w_funct)
                    F_SLL, F_SRL, F_SRA, F_SLLV, F_SRLV, F_SRAV: begin
                        w_legal           = 1'b1;
                        w_rt_src          = 1'b1;
                        w_dec.reg_dst     = DST_RD;
                        w_dec.alu_a_sel   = ~w_funct[2];
                        w_dec.alu         = shift_alu(w_funct[1:0]);
                        w_dec.reg_write   = 1'b1;
                    end
                    F_JR: begin
                        w_legal = 1'b1;
                        w_cti   = 1'b1;
                        w_taken = 1'b1;
                        w_tgt   = PC_JR;
                    end
                    F_MOVZ, F_MOVN: begin
                        if (EN_MOV != 0) begin
                            w_legal         = 1'b1;
                            w_rt_src        = 1'b1;
                            w_dec.reg_dst   = DST_RD;
                            w_dec.alu       = A_PASS;
                            // MOVZ writes on equal-to-zero, MOVN on the inverse
                            w_dec.reg_write = (rs_cmp_zero == CMP_EQ) ^ w_funct[0];
                        end
                    end
                    F_MFHI, F_MFLO: begin
                        w_legal         = 1'b1;
                        w_mdu_cls       = 1'b1;
                        w_dec.reg_dst   = DST_RD;
                        w_dec.reg_write = 1'b1;
                        w_dec.hilo_rd   = w_funct[1] ? HILO_LO : HILO_HI;
                    end
                    F_MULT, F_MULTU, F_DIV, F_DIVU: begin
                        w_legal      = 1'b1;
                        w_rt_src     = 1'b1;
                        w_mdu_cls    = 1'b1;
                        w_mdu_launch = 1'b1;
                        w_mdu_op     = mdu_op_e'(w_funct[1:0]);
                    end
                    F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR, F_XOR, F_NOR: begin
                        w_legal         = 1'b1;
                        w_rt_src        = 1'b1;
                        w_dec.reg_dst   = DST_RD;
                        w_dec.alu       = alu_op_e'(4'(w_funct[2:0]) + 4'd1);
                        w_dec.reg_write = 1'b1;
                    end
                    F_SLT, F_SLTU: begin
                        w_legal         = 1'b1;
                        w_rt_src        = 1'b1;
                        w_dec.reg_dst   = DST_RD;
                        w_dec.alu       = w_funct[0] ? A_SLTU : A_SLT;
                        w_dec.reg_write = 1'b1;
                    end
                    default: ;
                endcase
            end
            OP_REGIMM: begin
                // rt selects BLTZ (0) / BGEZ (1)
                if (w_rt[4:1] == 4'd0) begin
                    w_legal = 1'b1;
                    w_cti   = 1'b1;
                    w_tgt   = PC_BRANCH;
                    w_taken = (rs_cmp_zero == CMP_LT) ^ w_rt[0];
                end
            end
            OP_J: begin
                w_legal = 1'b1;
                w_cti   = 1'b1;
                w_taken = 1'b1;
                w_tgt   = PC_JUMP;
            end
            OP_BEQ, OP_BNE: begin
                w_legal  = 1'b1;
                w_rt_src = 1'b1;
                w_cti    = 1'b1;
                w_tgt    = PC_BRANCH;
                w_taken  = (rs_cmp_rt == CMP_EQ) ^ w_op[0];
            end
            OP_BLEZ, OP_BGTZ: begin
                w_legal = 1'b1;
                w_cti   = 1'b1;
                w_tgt   = PC_BRANCH;
                w_taken = ((rs_cmp_zero == CMP_GT) == w_op[0]);
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU: begin
                w_legal         = 1'b1;
                w_dec.alu_b_sel = BSEL_SIMM;
                w_dec.reg_write = 1'b1;
                case (w_op[1:0])
                    2'b00:   w_dec.alu = A_ADD;
                    2'b01:   w_dec.alu = A_ADDU;
                    2'b10:   w_dec.alu = A_SLT;
                    default: w_dec.alu = A_SLTU;
                endcase
            end
            OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                w_legal         = 1'b1;
                w_dec.alu_b_sel = BSEL_ZIMM;
                w_dec.reg_write = 1'b1;
                case (w_op[1:0])
                    2'b00:   w_dec.alu = A_AND;
                    2'b01:   w_dec.alu = A_OR;
                    2'b10:   w_dec.alu = A_XOR;
                    default: w_dec.alu = A_LUI;
                endcase
            end
            OP_LW: begin
                w_legal           = 1'b1;
                w_dec.alu_b_sel   = BSEL_SIMM;
                w_dec.alu         = A_ADDU;
                w_dec.dmem_read   = 1'b1;
                w_dec.dmem_to_reg = 1'b1;
                w_dec.reg_write   = 1'b1;
            end
            OP_SW: begin
                w_legal          = 1'b1;
                w_rt_src         = 1'b1;
                w_dec.alu_b_sel  = BSEL_SIMM;
                w_dec.alu        = A_ADDU;
                w_dec.dmem_write = 1'b1;
            end
            default: ;
        endcase
    end

    // Hazards: kill beats stall; illegal words never stall
    assign w_kill     = flush | ~id_valid;
    assign w_load_use = ex_dmem_read && (ex_rt != '0) &&
                        ((ex_rt == w_rs) || (w_rt_src && (ex_rt == w_rt)));
    assign w_stall    = ~w_kill & w_legal & (w_load_use | (mdu_busy & w_mdu_cls));
    assign w_accept   = ~w_kill & w_legal & ~w_stall;
    assign w_bun      = w_accept ? w_dec : '0;

    assign id_ready  = ~rst & ~w_stall;
    assign pc_src    = (~rst & w_accept & w_taken) ? w_tgt : PC_PLUS4;
    assign is_branch = ~rst & w_accept & w_cti;

    // ID/EX register; anything not accepted becomes a bubble
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid    <= 1'b0;
            reg_dst     <= '0;
            alu_a_sel   <= 1'b0;
            alu_b_sel   <= '0;
            alu_ctl     <= '0;
            dmem_read   <= 1'b0;
            dmem_write  <= 1'b0;
            dmem_to_reg <= 1'b0;
            reg_write   <= 1'b0;
            hilo_rd     <= '0;
            illegal     <= 1'b0;
        end else begin
            ex_valid    <= w_accept;
            reg_dst     <= w_bun.reg_dst;
            alu_a_sel   <= w_bun.alu_a_sel;
            alu_b_sel   <= w_bun.alu_b_sel;
            alu_ctl     <= ALUCTL_W'(w_bun.alu);
            dmem_read   <= w_bun.dmem_read;
            dmem_write  <= w_bun.dmem_write;
            dmem_to_reg <= w_bun.dmem_to_reg;
            reg_write   <= w_bun.reg_write;
            hilo_rd     <= w_bun.hilo_rd;
            illegal     <= ~w_kill & ~w_legal;
        end
    end

    mdu_sched #(.MDU_LAT(MDU_LAT)) u_mdu_sched (
        .clk      (clk),
        .rst      (rst),
        .i_launch (w_accept & w_mdu_launch),
        .i_op     (w_mdu_op),
        .o_start  (mdu_start),
        .o_op     (mdu_op),
        .o_busy   (mdu_busy)
    );

endmodule
